ddr_pair_deser: RTL and testbench
=================================

// Module: ddr_pair_deser
// PURPOSE
//  Consumes the serial output of the dual-edge (posedge+negedge) data flop and samples it on both clock edges.
//  Packs each {falling, rising} bit pair into WIDTH-bit words, MSB first, and hunts for a sync word to align them.
//  Presents aligned words on a valid/ready port to the downstream word consumer.
//  Sits directly after the dual-edge flop stage on the same clock.
// PARAMETERS
//  WIDTH      8      word width; must be even and >= 4
//  SYNC_WORD  8'hA5  alignment pattern; must be nonzero (the shift register resets to 0)
// PORTS
//  clk        in   1      single clock; both edges used
//  reset      in   1      asynchronous, active-high reset
//  din        in   1      serial data from the dual-edge flop; may change on either clk edge
//  din_en     in   1      stream enable, sampled at posedge; 0 aborts the frame
//  out_ready  in   1      consumer accepts out_data this cycle
//  out_valid  out  1      out_data holds an unconsumed word
//  out_data   out  WIDTH  aligned word, first-received bit in MSB
//  locked     out  1      1 when the state is LOCKED
//  overflow   out  1      sticky; a completed word was dropped
// BEHAVIOUR
//  - Reset (async, any time, including mid-word): fall_q=0, shreg=0, pair_cnt=0, state=HUNT.
//    Outputs on reset: out_valid=0, out_data=0, locked=0, overflow=0. No frame state survives reset.
//  - fall_q: din captured at every negedge clk.
//  - Each posedge with din_en=1: pair={fall_q,din}; shreg<={shreg[WIDTH-3:0],pair}.
//    Bit order within the pair: falling sample is earlier, so it becomes the higher bit.
//  - HUNT: after a shift, if the new shreg==SYNC_WORD, go to LOCKED and set pair_cnt=0.
//    The sync word is never output. Matching is at pair alignment only.
//  - LOCKED: every shift increments pair_cnt.
//    When pair_cnt==WIDTH/2-1, the new shreg is a complete word; pair_cnt wraps to 0.
//    Sync patterns seen while LOCKED are ignored and treated as data.
//  - Word completion with (!out_valid || out_ready): out_data<=word, out_valid<=1.
//    Latency: word is visible the cycle after the posedge that sampled its last rising bit.
//  - Word completion with out_valid && !out_ready: word is dropped, overflow<=1, out_data unchanged.
//  - Word completion in the same cycle as a handshake (out_valid && out_ready): new word loads, out_valid stays 1, no overflow.
//  - out_valid && out_ready with no completion: out_valid<=0 next cycle; out_data holds its value.
//  - din_en=0 in LOCKED: state goes to HUNT; shreg=0, pair_cnt=0 (partial word discarded).
//    A pending out_valid word is kept and can still be taken.
//  - din_en=0 in HUNT: no shift; state and shreg hold.
//  - overflow clears only on reset.
//  - Widths: pair_cnt is $clog2(WIDTH/2) bits and wraps explicitly.
//    No combinational path from inputs to outputs; all outputs are registered.
// STRUCTURE
//  - ddr_pair_deser_pkg: typedef enum logic {HUNT, LOCKED} deser_state_t; localparam PAIR_BITS=2.
//  - Sub-module ddr_fall_capture: the negedge-clocked din flop with async reset. It isolates the only negedge process.
//  - Top level: shift register, pair counter, FSM, and output register/handshake.
// TESTING (WIDTH=8, SYNC_WORD=8'hA5; a pair is written {fall,rise})
//  1. Pulse reset mid-word while out_valid=1, overflow=1 -> out_valid=0, locked=0, overflow=0 without waiting for a clk edge.
//  2. din_en=1, pairs 10,10,01,01 -> locked=1 after the 4th posedge; out_valid stays 0.
//  3. Locked, pairs 11,00,11,01 -> out_data=8'hCD, out_valid=1 the cycle after the 4th pair.
//  4. out_ready=0, words 8'h3C then 8'h81 -> out_data=8'h3C, overflow=1.
//     Then out_ready=1 -> out_valid=0 next cycle.
//  5. Locked, 2 pairs of a word, then din_en=0 -> locked=0.
//     Then resend A5 and 8'h12 -> out_data=8'h12; no word built from the partial bits.
//  6. out_valid=1 with out_ready=1 on the same cycle 8'h5A completes -> out_data=8'h5A, out_valid stays 1, overflow=0.

Source files
------------

// File: rtl/ddr_pair_deser_pkg.sv
// Shared types and constants for the DDR pair deserializer.
package ddr_pair_deser_pkg;

  // Framing state: hunting for the sync word, or locked to word boundaries.
  typedef enum logic {HUNT, LOCKED} deser_state_t;

  // Bits gathered per clock: one on the falling edge, one on the rising edge.
  localparam int PAIR_BITS = 2;

endpackage

// File: rtl/ddr_pair_deser_fall_capture.sv
// Falling-edge capture of the serial stream. This is the only negedge
// process in the block; everything downstream runs on the rising edge.
module ddr_fall_capture (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic fall_q
);

  // Hold the falling-edge sample for pairing with the next rising-edge bit.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) fall_q <= 1'b0;
    else       fall_q <= din;
  end

endmodule

// File: rtl/ddr_pair_deser.sv
// DDR pair deserializer: packs {fall, rise} bit pairs MSB-first into words,
// aligns on a sync word and presents aligned words on a valid/ready port.
module ddr_pair_deser
  import ddr_pair_deser_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] SYNC_WORD = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_en,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             locked,
  output logic             overflow
);

  localparam int             CNT_W    = $clog2(WIDTH / PAIR_BITS);
  localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(WIDTH / PAIR_BITS - 1);

  deser_state_t         state, state_nxt;
  logic                 fall_q;
  logic [PAIR_BITS-1:0] pair;
  logic [WIDTH-1:0]     shreg, shreg_nxt;
  logic [CNT_W-1:0]     pair_cnt;
  logic                 sync_hit;
  logic                 word_done;

  ddr_fall_capture u_fall (
    .clk    (clk),
    .reset  (reset),
    .din    (din),
    .fall_q (fall_q)
  );

  // Falling sample arrived first, so it takes the higher bit of the pair.
  assign pair      = {fall_q, din};
  assign shreg_nxt = {shreg[WIDTH-PAIR_BITS-1:0], pair};
  assign sync_hit  = (state == HUNT) && din_en && (shreg_nxt == SYNC_WORD);
  assign word_done = (state == LOCKED) && din_en && (pair_cnt == LAST_PAIR);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HUNT;
    else       state <= state_nxt;
  end

  // Next state: lock on a pair-aligned sync match, drop lock when the stream stops.
  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:    if (sync_hit) state_nxt = LOCKED;
      LOCKED:  if (!din_en)  state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

  // State-derived outputs; state is a flop so locked is registered.
  always_comb begin
    locked = (state == LOCKED);
  end

  // Shift register: shifts on every enabled pair; cleared when a locked frame aborts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          shreg <= '0;
    else if (din_en)                    shreg <= shreg_nxt;
    else if (state == LOCKED)           shreg <= '0;
  end

  // Pair counter: position of the next pair within the current word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       pair_cnt <= '0;
    else if (sync_hit)               pair_cnt <= '0;
    else if (state == LOCKED) begin
      if (!din_en)                   pair_cnt <= '0;
      else if (pair_cnt == LAST_PAIR) pair_cnt <= '0;
      else                           pair_cnt <= pair_cnt + CNT_W'(1);
    end
  end

  // Output register and handshake; a word that finds the slot full is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else if (word_done) begin
      if (!out_valid || out_ready) begin
        out_valid <= 1'b1;
        out_data  <= shreg_nxt;
      end else begin
        overflow  <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ddr_pair_deser.sv
// Bench for ddr_pair_deser: directed sequences followed by random traffic,
// checked by a bit-queue reference model feeding a scoreboard.
module tb_ddr_pair_deser;

  localparam int         W    = 8;
  localparam logic [7:0] SYNC = 8'hA5;

  logic         clk = 1'b0;
  logic         reset;
  logic         din;
  logic         din_en;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         locked;
  logic         overflow;

  int total = 0;
  int bad   = 0;

  ddr_pair_deser #(.WIDTH(W), .SYNC_WORD(SYNC)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_en    (din_en),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .locked    (locked),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit           m_fall;
  bit           m_hist[$];
  bit           m_wbits[$];
  bit           m_locked;
  bit           m_full;
  bit           m_ovf;
  logic [W-1:0] m_data;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] qval(input bit q[$]);
    logic [W-1:0] v = '0;
    foreach (q[i]) v = {v[W-2:0], q[i]};
    return v;
  endfunction

  task automatic hist_clear();
    m_hist.delete();
    repeat (W) m_hist.push_back(1'b0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk or posedge reset);
      if (reset) m_fall = 1'b0;
      else       m_fall = din;
    end
  end

  initial begin
    bit           done;
    logic [W-1:0] word;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        hist_clear();
        m_wbits.delete();
        m_locked = 0; m_full = 0; m_ovf = 0; m_data = '0;
        exp_q.delete();
      end else begin
        done = 0;
        word = '0;
        if (din_en) begin
          m_hist.push_back(m_fall); m_hist.push_back(din);
          void'(m_hist.pop_front()); void'(m_hist.pop_front());
          if (!m_locked) begin
            if (qval(m_hist) == SYNC) begin
              m_locked = 1;
              m_wbits.delete();
            end
          end else begin
            m_wbits.push_back(m_fall); m_wbits.push_back(din);
            if (m_wbits.size() == W) begin
              done = 1;
              word = qval(m_wbits);
              m_wbits.delete();
            end
          end
        end else if (m_locked) begin
          m_locked = 0;
          hist_clear();
          m_wbits.delete();
        end
        if (done) begin
          if (!m_full || out_ready) begin
            m_full = 1; m_data = word; exp_q.push_back(word);
          end else begin
            m_ovf = 1;
          end
        end else if (m_full && out_ready) begin
          m_full = 0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("out_valid", 32'(out_valid), 32'(m_full));
        check("locked",    32'(locked),    32'(m_locked));
        check("overflow",  32'(overflow),  32'(m_ovf));
        check("out_data",  32'(out_data),  32'(m_data));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("sb_underrun", 32'(exp_q.size()), 32'd1);
          else begin
            e = exp_q.pop_front();
            check("sb_word", 32'(out_data), 32'(e));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called 1 time unit after a posedge; returns 1 after the posedge that samples the pair.
  task automatic send_pair(input bit f, input bit r, input bit en, input bit rdy);
    din = f; din_en = en; out_ready = rdy;
    @(negedge clk); #1;
    din = r;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [3:0] rdy);
    for (int i = 0; i < 4; i++) send_pair(b[7-2*i], b[6-2*i], 1'b1, rdy[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    reset = 1; din = 0; din_en = 0; out_ready = 0;
    @(posedge clk); #1;
    check("rst_valid",  32'(out_valid), 32'd0);
    check("rst_locked", 32'(locked),    32'd0);
    check("rst_ovf",    32'(overflow),  32'd0);
    check("rst_data",   32'(out_data),  32'd0);
    reset = 0;
    @(posedge clk); #1;

    // lock on A5; the sync word itself is not output
    send_byte(8'hA5, 4'b0000);
    check("t2_locked", 32'(locked),    32'd1);
    check("t2_valid",  32'(out_valid), 32'd0);

    // first data word
    send_byte(8'hCD, 4'b0000);
    check("t3_valid", 32'(out_valid), 32'd1);
    check("t3_data",  32'(out_data),  32'hCD);

    // completion in the same cycle as a handshake
    send_byte(8'h5A, 4'b1000);
    check("t6_valid", 32'(out_valid), 32'd1);
    check("t6_data",  32'(out_data),  32'h5A);
    check("t6_ovf",   32'(overflow),  32'd0);

    // second word dropped while the first is pending
    send_byte(8'h3C, 4'b0001);
    check("t4_first", 32'(out_data), 32'h3C);
    send_byte(8'h81, 4'b0000);
    check("t4_data", 32'(out_data),  32'h3C);
    check("t4_ovf",  32'(overflow),  32'd1);

    // async reset mid-word, between clock edges
    send_pair(1, 0, 1, 0);
    send_pair(0, 1, 1, 0);
    #1 reset = 1;
    #1;
    check("t1_valid",  32'(out_valid), 32'd0);
    check("t1_locked", 32'(locked),    32'd0);
    check("t1_ovf",    32'(overflow),  32'd0);
    check("t1_data",   32'(out_data),  32'd0);
    #1 reset = 0;

    // abort a partial word, relock, and make sure the partial bits are gone
    send_byte(8'hA5, 4'b0000);
    send_pair(1, 1, 1, 0);
    send_pair(1, 1, 1, 0);
    send_pair(0, 0, 0, 0);
    check("t5_unlock", 32'(locked), 32'd0);
    send_byte(8'hA5, 4'b0000);
    check("t5_relock", 32'(locked), 32'd1);
    send_byte(8'h12, 4'b0000);
    check("t5_valid", 32'(out_valid), 32'd1);
    check("t5_data",  32'(out_data),  32'h12);
    send_pair(0, 1, 1, 1);
    check("t4_drain", 32'(out_valid), 32'd0);
    check("t4_hold",  32'(out_data),  32'h12);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 7))
        0:       rb = 8'hA5;
        1:       rb = 8'h00;
        default: rb = 8'($urandom);
      endcase
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(1, 2)) send_pair(1'($urandom), 1'($urandom), 0, 1'($urandom));
      end
      for (int i = 0; i < 4; i++)
        send_pair(rb[7-2*i], rb[6-2*i], ($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0));
    end

    // drain: stop the stream, take any pending word
    send_pair(0, 0, 0, 1);
    send_pair(0, 0, 0, 1);
    check("drain_q", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
